memory_interface: RTL

MEMORY_INTERFACE -- requirements
Module: memory_interface

---
 rtl/memory_interface_if.sv | 23 ++
 rtl/memory_interface.sv | 119 +++++++++++
 2 files changed

// File: rtl/memory_interface_if.sv
// rtl/memory_interface_if.sv - CPU bus to memory interface signal bundle
interface memory_interface_if;
    logic [31:0] BusMuxOut;
    logic        MARin;
    logic        MDRin;
    logic        Read;
    logic        Write;
    logic [31:0] MDRout_data;
    logic [8:0]  MAR_q;
    logic        Busy;
    logic        Ready;
    logic        ProtErr;

    modport master (
        output BusMuxOut, MARin, MDRin, Read, Write,
        input  MDRout_data, MAR_q, Busy, Ready, ProtErr
    );

    modport slave (
        input  BusMuxOut, MARin, MDRin, Read, Write,
        output MDRout_data, MAR_q, Busy, Ready, ProtErr
    );
endinterface

// File: rtl/memory_interface.sv
// rtl/memory_interface.sv - MAR/MDR memory port with wait states, edge-triggered requests
module memory_interface #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    memory_interface_if.slave mif
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    logic [31:0] mem [0:511];

    state_t      state;
    logic [8:0]  mar_q;
    logic [8:0]  acc_addr;
    logic [31:0] mdr_q;
    logic [31:0] wr_data;
    logic [2:0]  wait_cnt;
    logic        rd_prev;
    logic        wr_prev;
    logic        hist_valid;
    logic        busy_q;
    logic        ready_q;
    logic        prot_q;

    logic rd_rise;
    logic wr_rise;
    logic illegal;
    logic wait_done;
    logic mem_we;

    // The first sample after reset only records history, so a level held
    // across reset is never mistaken for a fresh request.
    assign rd_rise   = hist_valid & mif.Read  & ~rd_prev;
    assign wr_rise   = hist_valid & mif.Write & ~wr_prev;
    assign illegal   = (rd_rise & mif.Write) | (wr_rise & mif.Read);
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign mem_we    = !Reset && (state == WR_WAIT) && wait_done;

    // Memory has no reset: contents survive Reset, and an aborted write never lands.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[acc_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            mar_q      <= '0;
            mdr_q      <= '0;
            wait_cnt   <= '0;
            rd_prev    <= 1'b0;
            wr_prev    <= 1'b0;
            hist_valid <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            prot_q     <= 1'b0;
        end else begin
            rd_prev    <= mif.Read;
            wr_prev    <= mif.Write;
            hist_valid <= 1'b1;
            ready_q    <= 1'b0;
            prot_q     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (mif.MARin) begin
                        mar_q <= mif.BusMuxOut[8:0];
                    end
                    if (mif.MDRin && !mif.Read) begin
                        mdr_q <= mif.BusMuxOut;
                    end
                    // Access address is the pre-edge MAR even if MARin fires on this edge.
                    if (illegal) begin
                        prot_q <= 1'b1;
                    end else if (wr_rise) begin
                        state    <= WR_WAIT;
                        busy_q   <= 1'b1;
                        acc_addr <= mar_q;
                        wr_data  <= mif.BusMuxOut;
                        wait_cnt <= '0;
                    end else if (rd_rise && mif.MDRin) begin
                        state    <= RD_WAIT;
                        busy_q   <= 1'b1;
                        acc_addr <= mar_q;
                        wait_cnt <= '0;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (wait_done) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        wait_cnt <= '0;
                        mdr_q    <= (state == RD_WAIT) ? mem[acc_addr] : wr_data;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mif.MDRout_data = mdr_q;
    assign mif.MAR_q       = mar_q;
    assign mif.Busy        = busy_q;
    assign mif.Ready       = ready_q;
    assign mif.ProtErr     = prot_q;

endmodule
